// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud constant and parity/width helpers.
// Pure declarations; no logic, latency or flow control.
package uart_pkg;

  localparam int BAUD_115200_CLKS = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Never returns zero, so it can size counters and indices for small parameters.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Parity bit a transmitter would send for this word (unused upper bits must be zero).
  function automatic logic par_calc(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an idle-high asynchronous line; resets to 1.
// Latency 2 cycles; no flow control.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// Serial frame receiver: mid-bit sampling, optional parity, 1-2 stop bits, one-cycle out_valid.
// Latency ~2 + CLKS_PER_BIT/2 + bits*CLKS_PER_BIT + 1 cycles from start edge; no backpressure, words are not held off.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = BAUD_115200_CLKS,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 inBit,
  output logic [DATA_BITS-1:0] out,
  output logic                 out_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = clog2_safe(CLKS_PER_BIT);
  localparam int IDX_W = clog2_safe(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             ODD       = (PARITY_ODD != 0);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  logic rx_s;

  sync2 u_sync (
    .clk  (CLOCK_50),
    .rst_n(reset_n),
    .d    (inBit),
    .q    (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic [8:0]           par_word;
  logic                 ferr_now;

  always_comb begin
    par_word = '0;
    par_word[DATA_BITS-1:0] = shreg_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    stop_idx_d   = stop_idx_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    out_d        = out_q;
    out_valid_d  = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    ferr_now     = ferr_q | ~rx_s;

    unique case (state_q)
      IDLE: begin
        if (enable && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
            shreg_d = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          if (idx_q == DATA_LAST) begin
            state_d    = HAS_PAR ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          perr_d  = (par_calc(par_word, ODD) != rx_s);
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d  = '0;
          ferr_d = ferr_now;
          if (stop_idx_q == STOP_LAST) begin
            // Word is delivered even on error; a held-low line parks in WAIT_IDLE.
            out_d        = shreg_q;
            out_valid_d  = 1'b1;
            parity_err_d = perr_q;
            frame_err_d  = ferr_now;
            state_d      = ferr_now ? WAIT_IDLE : IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      stop_idx_q   <= 1'b0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stop_idx_q   <= stop_idx_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboarded bench: one 8N1 receiver and one 8E1 receiver, both at 8 clocks per bit.
module tb_uart_rx_frame;

  localparam int CPB = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b;
  logic       rx_a, rx_b;
  logic [7:0] out_a, out_b;
  logic       val_a, val_b, pe_a, pe_b, fe_a, fe_b, busy_a, busy_b;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  uart_rx_frame #(.CLKS_PER_BIT(CPB)) u_dut_a (
    .CLOCK_50  (clk),
    .reset_n   (rst_n),
    .enable    (en_a),
    .inBit     (rx_a),
    .out       (out_a),
    .out_valid (val_a),
    .parity_err(pe_a),
    .frame_err (fe_a),
    .busy      (busy_a)
  );

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_b (
    .CLOCK_50  (clk),
    .reset_n   (rst_n),
    .enable    (en_b),
    .inBit     (rx_b),
    .out       (out_b),
    .out_valid (val_b),
    .parity_err(pe_b),
    .frame_err (fe_b),
    .busy      (busy_b)
  );

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    return e;
  endfunction

  // Monitors: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (val_a) begin
      if (q_a.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL a_unexpected_strobe: got strobe with out=0x%0h, required none", out_a);
      end else begin
        ea = q_a.pop_front();
        check("a_out", int'(out_a), int'(ea.d));
        check("a_parity_err", int'(pe_a), int'(ea.pe));
        check("a_frame_err", int'(fe_a), int'(ea.fe));
      end
    end
  end

  always @(negedge clk) begin
    if (val_b) begin
      if (q_b.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL b_unexpected_strobe: got strobe with out=0x%0h, required none", out_b);
      end else begin
        eb = q_b.pop_front();
        check("b_out", int'(out_b), int'(eb.d));
        check("b_parity_err", int'(pe_b), int'(eb.pe));
        check("b_frame_err", int'(fe_b), int'(eb.fe));
      end
    end
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input bit pbit, input bit stop_v, input bit drop_en);
    drive(sel, 1'b0);
    if (drop_en) en_a = 1'b0;
    for (int i = 0; i < 8; i++) drive(sel, d[i]);
    if (has_par) drive(sel, pbit);
    drive(sel, stop_v);
  endtask

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out", int'(out_a), 0);
    check("reset_valid", int'(val_a), 0);
    check("reset_parity_err", int'(pe_a), 0);
    check("reset_frame_err", int'(fe_a), 0);
    check("reset_busy", int'(busy_a), 0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // Plain 8N1 frame
    q_a.push_back(mk(8'hA5, 1'b0, 1'b0));
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_busy_after", int'(busy_a), 0);
    repeat (CPB) @(negedge clk);

    // Even parity: 0x03 has two ones, so parity bit 1 is wrong and 0 is right
    q_b.push_back(mk(8'h03, 1'b1, 1'b0));
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    q_b.push_back(mk(8'h03, 1'b0, 1'b0));
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);

    // Three-cycle glitch is rejected at the mid-start sample
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_start", int'(busy_a), 1);
    repeat (6) @(negedge clk);
    check("glitch_busy_fallen", int'(busy_a), 0);
    repeat (CPB) @(negedge clk);

    // Stop bit low, then break held 40 cycles
    q_a.push_back(mk(8'h0F, 1'b0, 1'b1));
    send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("break_busy_held", int'(busy_a), 1);
    repeat (20) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("break_busy_released", int'(busy_a), 0);

    // Reset after four data bits abandons the frame
    drive(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_out", int'(out_a), 0);
    check("midreset_frame_err", int'(fe_a), 0);
    check("midreset_busy", int'(busy_a), 0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    q_a.push_back(mk(8'h3C, 1'b0, 1'b0));
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);

    // Disabled receiver ignores a whole frame
    en_a = 1'b0;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    check("disabled_busy", int'(busy_a), 0);
    repeat (2 * CPB) @(negedge clk);
    en_a = 1'b1;

    // enable dropped after the start bit: frame still completes
    q_a.push_back(mk(8'h55, 1'b0, 1'b0));
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (CPB) @(negedge clk);
    en_a = 1'b1;

    // Back-to-back frames with no idle gap
    q_a.push_back(mk(8'h12, 1'b0, 1'b0));
    q_a.push_back(mk(8'h34, 1'b0, 1'b0));
    send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(1'b0, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4 * CPB) @(negedge clk);

    check("a_pending_expectations", q_a.size(), 0);
    check("b_pending_expectations", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised serial frame receiver that supersedes the fixed 10-bit shift receiver. It handles a configurable bit period, data width, optional parity and 1 or 2 stop bits. It synchronises the raw serial line, finds each start bit, samples at mid-bit, checks parity and stop bits, and presents parallel data with a one-cycle valid strobe. It sits between the board serial pin and the accumulator datapath.

Parameters:
CLKS_PER_BIT, 434, CLOCK_50 cycles per serial bit (115200 baud); legal minimum 4
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY_EN, 0, 1 = a parity bit follows the data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0
STOP_BITS, 1, 1 or 2

Ports:
CLOCK_50  input  1  system clock; all logic is on the rising edge
reset_n  input  1  synchronous active-low reset
enable  input  1  1 = new frames may start
inBit  input  1  raw asynchronous serial line, idle high
out  output  DATA_BITS  last received data word, first-received bit in out[0]
out_valid  output  1  one-cycle strobe; a new word is on out
parity_err  output  1  parity status of the last word
frame_err  output  1  stop-bit status of the last word
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at a clock edge): FSM goes to IDLE; out=0, out_valid=0, parity_err=0, frame_err=0, busy=0; both synchroniser flops are set to 1. Reset mid-frame abandons the frame and produces no strobe.
- Input path: a 2-flop synchroniser produces rx_s. All decisions use rx_s only, which adds 2 cycles of input latency.
- Bit-timing counter is $clog2(CLKS_PER_BIT) bits wide. The half-period is CLKS_PER_BIT/2, using integer division.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: if enable=1 and rx_s=0, go to START and clear the counter. If enable=0, stay in IDLE regardless of the line.
- START: wait for the half-period, then sample. If rx_s=0, go to DATA with bit index 0 and the counter cleared. If rx_s=1, treat it as a glitch and return to IDLE with no strobe and no error.
- DATA: sample every CLKS_PER_BIT cycles, shifting into bit [index] LSB-first. After bit DATA_BITS-1, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: sample once after CLKS_PER_BIT cycles. A parity error occurs when the XOR of data and the parity bit is not equal to PARITY_ODD.
- STOP: sample STOP_BITS stop bits, each CLKS_PER_BIT apart. Any sampled 0 sets the pending frame error.
- Completion, on the cycle after the final stop sample:
  - out is loaded with the word.
  - out_valid=1 for exactly 1 cycle.
  - parity_err and frame_err are loaded with the pending flags and held until the next strobe.
  - The data is delivered even when an error flag is set.
- After completion:
  - With no frame error, the FSM returns to IDLE.
  - With a frame error, it goes to WAIT_IDLE and stays there until rx_s=1, so a break condition cannot retrigger a frame.
- enable dropping mid-frame has no effect; the frame completes normally.
- out changes only on the strobe cycle. busy is combinational from the state.
- Back-to-back frames: a start edge on the first cycle back in IDLE is accepted.
- Total latency from the start edge on the pin to out_valid:
  2 + CLKS_PER_BIT/2 + (DATA_BITS + PARITY_EN + STOP_BITS)·CLKS_PER_BIT + 1 cycles (±1).

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (rx_state_t);
  - the function clog2_safe;
  - the constant BAUD_115200_CLKS=434;
  - a parity function par_calc(data, odd).
- Sub-module sync2 (2-flop synchroniser, reset to 1) is natural and reusable by the TX side.

Test Plan:
All tests use CLKS_PER_BIT=8.
- Default format, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one out_valid pulse, out=0xA5, parity_err=0, frame_err=0, busy=0 afterwards.
- PARITY_EN=1, PARITY_ODD=0, send 0x03 with parity bit 1 -> out=0x03, parity_err=1; resend with parity bit 0 -> parity_err=0.
- Stop bit driven 0, then the line held low for 40 cycles before returning high -> out_valid with frame_err=1; busy stays high until the line goes high; no second frame is detected.
- 3-cycle low glitch on an idle line -> no out_valid, state back to IDLE, busy falls within 8 cycles.
- Reset pulse mid-frame after 4 data bits, then a clean 0x3C frame -> no strobe for the aborted frame; out=0x3C with flags 0.
- enable=0 while a 0x55 frame is sent -> no strobe. Next, enable goes 1→0 after the start bit of 0x55 -> frame completes, out=0x55. Two back-to-back frames 0x12, 0x34 -> two strobes in order.
